railway_cart_ctrl: RTL and testbench
====================================

Name: railway_cart_ctrl

Overview:
Parametrised railway-cart position controller. It drives a one-hot-style bar of CART_W lit bits along a TRACK_W-bit track display. Manual mode uses a two-press arm/confirm sequence. Auto mode steps the cart at a programmable rate, either stopping at the ends or bouncing between them. It sits between the debounced pushbutton/switch front end and the LED track display.

Parameters:
TRACK_W, 8, track length in bits (width of POS); must be > CART_W
CART_W, 2, cart length in lit bits; must be ≥ 1
STEP_DIV, 4, clock cycles per auto step; must be ≥ 1
BOUNCE, 0, auto end behaviour: 0 = stop at end, 1 = reverse at end

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
RIGHT  in  1  single-cycle pulse, already debounced upstream
LEFT  in  1  single-cycle pulse, already debounced upstream
DIR  in  1  auto direction: 0 = right (toward LSB), 1 = left (toward MSB)
AUTO  in  1  level: 1 = auto mode, 0 = manual mode
POS  out  TRACK_W  cart bar: CART_W contiguous ones
STEP  out  1  one-cycle pulse on every cycle in which POS changes
MOVING  out  1  1 while in auto and the cart is not halted
ARMED  out  1  1 in ARM_R or ARM_L
AT_LEFT  out  1  cart occupies the MSBs
AT_RIGHT  out  1  cart occupies the LSBs

Behaviour:
- Reset: synchronous, active-high; applies on the CLK edge where RESET=1 and overrides every other input, including mid-move.
  - Reset values: state=IDLE, idx=0, div_cnt=0, POS = CART_W ones in the MSBs (8'hC0 at defaults).
  - Reset values: STEP=0, MOVING=0, ARMED=0, AT_LEFT=1, AT_RIGHT=0.
- Position and derived outputs:
  - Internal idx ranges 0..MAXI, where MAXI = TRACK_W−CART_W. idx 0 is leftmost; idx never leaves this range.
  - POS = ({CART_W{1}} << (TRACK_W−CART_W)) >> idx. POS, AT_LEFT (idx==0) and AT_RIGHT (idx==MAXI) are registered and consistent with idx.
  - STEP is registered and asserted in the same cycle POS first shows the new value.
- States: IDLE, ARM_R, ARM_L, AUTO_RUN, AUTO_HALT.
- Manual transitions, all with AUTO=0:
  - IDLE: RIGHT alone → ARM_R. LEFT alone → ARM_L. RIGHT and LEFT in the same cycle → ignored, stay IDLE.
  - ARM_R: LEFT alone → confirm move right, idx+1 unless idx==MAXI, → IDLE. RIGHT alone → cancel → IDLE. Both → ignored, stay ARM_R.
  - ARM_L: RIGHT alone → confirm move left, idx−1 unless idx==0, → IDLE. LEFT alone → cancel → IDLE. Both → ignored, stay ARM_L.
  - Confirm latency: a confirm pulse sampled at edge k updates POS and asserts STEP after edge k, for one cycle.
  - A confirm toward the wall the cart is already at leaves POS unchanged, gives no STEP, and returns to IDLE.
  - No timeout: an armed state holds indefinitely.
- Auto mode:
  - AUTO sampled 1 in any manual state → AUTO_RUN with div_cnt=0. Any armed state is discarded.
  - On entry, cur_dir is loaded from DIR. With BOUNCE=0, cur_dir follows DIR every cycle. With BOUNCE=1, DIR is ignored after entry.
  - In AUTO_RUN, div_cnt increments each cycle. A tick occurs when div_cnt==STEP_DIV−1, after which div_cnt wraps to 0.
  - First tick: AUTO sampled at edge k gives the first POS change after edge k+STEP_DIV.
  - Tick, not at the wall in cur_dir → idx moves one step in cur_dir, STEP=1.
  - Tick at the wall with BOUNCE=1 → cur_dir flips and there is no move on that tick (a dwell tick). The cart moves away on the next tick.
  - Tick at the wall with BOUNCE=0 → AUTO_HALT: MOVING=0, div_cnt held at 0.
  - AUTO_HALT (BOUNCE=0 only): if DIR now points away from the wall → AUTO_RUN with div_cnt=0.
  - MOVING=1 in AUTO_RUN only.
  - RIGHT/LEFT are ignored in AUTO_RUN and AUTO_HALT.
- Leaving auto: AUTO sampled 0 in AUTO_RUN or AUTO_HALT → IDLE, POS held, div_cnt=0, MOVING=0.
- RESET and AUTO together: RESET wins.
- No combinational path from inputs to outputs.

Test Plan:
1. Assert RESET for 2 cycles (defaults) → POS=8'hC0, AT_LEFT=1, AT_RIGHT=0, STEP=0, MOVING=0, ARMED=0.
2. Manual move and cancel:
   - From reset, RIGHT pulse → ARMED=1; LEFT pulse 3 cycles later → POS=8'h60 and STEP=1 for one cycle, ARMED=0.
   - Then RIGHT, RIGHT → POS stays 8'h60, ARMED returns 0.
3. Auto stop, BOUNCE=0, STEP_DIV=4, DIR=0, from POS=8'hC0:
   - AUTO=1 → POS steps 60,30,18,0C,06,03, one step every 4 cycles; first change 4 cycles after AUTO is sampled.
   - After reaching 03: AUTO_HALT, MOVING=0, AT_RIGHT=1.
   - Then set DIR=1 → cart resumes left, 8'h06 after 4 cycles.
4. Auto bounce, BOUNCE=1, AUTO from POS=8'h06 with DIR=0 → 03 after 4 cycles, dwell tick at 8 cycles with no STEP, 06 at 12 cycles. Toggling DIR during the run has no effect.
5. Boundaries:
   - At POS=8'hC0: LEFT then RIGHT → no change, no STEP.
   - RIGHT and LEFT pulsed in the same cycle → ARMED stays 0.
   - AUTO dropped mid-run at POS=8'h18 → POS holds 8'h18, MOVING=0.
6. RESET mid-run while AUTO=1 at POS=8'h0C → POS=8'hC0 after that edge. The cart then takes 4 cycles to show 8'h60 with AUTO still 1.

Source files
------------

// File: rtl/railway_cart_ctrl_if.sv
// railway_cart_ctrl_if: button/switch inputs and track display outputs
// shared between the front end and the cart controller.
interface railway_cart_ctrl_if #(
    parameter int TRACK_W = 8
);
    logic               RIGHT;
    logic               LEFT;
    logic               DIR;
    logic               AUTO;
    logic [TRACK_W-1:0] POS;
    logic               STEP;
    logic               MOVING;
    logic               ARMED;
    logic               AT_LEFT;
    logic               AT_RIGHT;

    modport master (
        output RIGHT, LEFT, DIR, AUTO,
        input  POS, STEP, MOVING, ARMED, AT_LEFT, AT_RIGHT
    );

    modport slave (
        input  RIGHT, LEFT, DIR, AUTO,
        output POS, STEP, MOVING, ARMED, AT_LEFT, AT_RIGHT
    );
endinterface

// File: rtl/railway_cart_ctrl.sv
// railway_cart_ctrl: cart bar position controller for the LED track display.
// Manual arm/confirm moves plus timed auto stepping that stops or bounces.
module railway_cart_ctrl #(
    parameter int TRACK_W  = 8,
    parameter int CART_W   = 2,
    parameter int STEP_DIV = 4,
    parameter int BOUNCE   = 0
) (
    input logic CLK,
    input logic RESET,
    railway_cart_ctrl_if.slave bus
);
    localparam int MAXI = TRACK_W - CART_W;
    localparam int IW   = $clog2(MAXI + 1);
    localparam int DW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [IW-1:0] IMAX  = IW'(MAXI);
    localparam logic [DW-1:0] DLAST = DW'(STEP_DIV - 1);
    localparam logic [TRACK_W-1:0] BAR = {{CART_W{1'b1}}, {MAXI{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, ARM_R, ARM_L, AUTO_RUN, AUTO_HALT
    } state_t;

    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] div_q, div_d;
    logic dir_q, dir_d;
    logic [TRACK_W-1:0] pos_q;
    logic step_q, left_q, right_q;

    logic at_l, at_r, r_only, l_only, run_dir, wall;

    assign at_l   = (idx_q == '0);
    assign at_r   = (idx_q == IMAX);
    assign r_only = bus.RIGHT & ~bus.LEFT;
    assign l_only = bus.LEFT & ~bus.RIGHT;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        div_d   = div_q;
        dir_d   = dir_q;
        run_dir = (BOUNCE != 0) ? dir_q : bus.DIR;
        wall    = run_dir ? at_l : at_r;
        unique case (state_q)
            IDLE, ARM_R, ARM_L: begin
                if (bus.AUTO) begin
                    state_d = AUTO_RUN;
                    div_d   = '0;
                    dir_d   = bus.DIR;
                end else if (state_q == IDLE) begin
                    if (r_only)      state_d = ARM_R;
                    else if (l_only) state_d = ARM_L;
                end else if (state_q == ARM_R) begin
                    if (l_only) begin
                        if (!at_r) idx_d = idx_q + 1'b1;
                        state_d = IDLE;
                    end else if (r_only) begin
                        state_d = IDLE;
                    end
                end else begin
                    if (r_only) begin
                        if (!at_l) idx_d = idx_q - 1'b1;
                        state_d = IDLE;
                    end else if (l_only) begin
                        state_d = IDLE;
                    end
                end
            end
            AUTO_RUN: begin
                if (!bus.AUTO) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else begin
                    if (BOUNCE == 0) dir_d = bus.DIR;
                    if (div_q == DLAST) begin
                        div_d = '0;
                        if (!wall)
                            idx_d = run_dir ? idx_q - 1'b1 : idx_q + 1'b1;
                        else if (BOUNCE != 0)
                            dir_d = ~dir_q;
                        else
                            state_d = AUTO_HALT;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            AUTO_HALT: begin
                div_d = '0;
                if (!bus.AUTO) begin
                    state_d = IDLE;
                end else if ((at_r && bus.DIR) || (at_l && !bus.DIR)) begin
                    state_d = AUTO_RUN;
                    dir_d   = bus.DIR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Display flags are registered from the next index so they land with POS.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            div_q   <= '0;
            dir_q   <= 1'b0;
            pos_q   <= BAR;
            step_q  <= 1'b0;
            left_q  <= 1'b1;
            right_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
            pos_q   <= BAR >> idx_d;
            step_q  <= (idx_d != idx_q);
            left_q  <= (idx_d == '0);
            right_q <= (idx_d == IMAX);
        end
    end

    assign bus.POS      = pos_q;
    assign bus.STEP     = step_q;
    assign bus.MOVING   = (state_q == AUTO_RUN);
    assign bus.ARMED    = (state_q == ARM_R) || (state_q == ARM_L);
    assign bus.AT_LEFT  = left_q;
    assign bus.AT_RIGHT = right_q;
endmodule

// File: tb/tb_railway_cart_ctrl.sv
// tb_railway_cart_ctrl: stop-mode and bounce-mode controllers driven by
// directed and random stimulus, checked against a behavioural cart model.
module tb_railway_cart_ctrl;
    localparam int TW = 8;
    localparam int CW = 2;
    localparam int SD = 4;
    localparam int MAXI = TW - CW;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    railway_cart_ctrl_if #(.TRACK_W(TW)) if0 ();
    railway_cart_ctrl_if #(.TRACK_W(TW)) if1 ();

    railway_cart_ctrl #(
        .TRACK_W(TW), .CART_W(CW), .STEP_DIV(SD), .BOUNCE(0)
    ) u0 (
        .CLK(CLK), .RESET(RESET), .bus(if0)
    );

    railway_cart_ctrl #(
        .TRACK_W(TW), .CART_W(CW), .STEP_DIV(SD), .BOUNCE(1)
    ) u1 (
        .CLK(CLK), .RESET(RESET), .bus(if1)
    );

    int tests = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int idx;
        int arm;
        bit auto_on;
        bit halted;
        int age;
        bit cdir;
        bit step;
    } m_t;

    m_t m0, m1;

    function automatic m_t mstep(m_t m, bit bounce, bit r, bit l,
                                 bit dir, bit au, bit rst);
        int old;
        int tgt;
        int p;
        old = m.idx;
        if (rst) begin
            m.idx = 0; m.arm = 0; m.auto_on = 0; m.halted = 0;
            m.age = 0; m.cdir = 0; m.step = 0;
            return m;
        end
        if (!m.auto_on) begin
            if (au) begin
                m.auto_on = 1; m.halted = 0; m.age = 0;
                m.cdir = dir; m.arm = 0;
            end else if (r ^ l) begin
                p = r ? 1 : -1;
                if (m.arm == 0) m.arm = p;
                else if (m.arm == p) m.arm = 0;
                else begin
                    tgt = m.idx + m.arm;
                    if (tgt >= 0 && tgt <= MAXI) m.idx = tgt;
                    m.arm = 0;
                end
            end
        end else if (!au) begin
            m.auto_on = 0;
            m.arm = 0;
        end else if (m.halted) begin
            if ((m.idx == MAXI && dir) || (m.idx == 0 && !dir)) begin
                m.halted = 0; m.age = 0; m.cdir = dir;
            end
        end else begin
            if (!bounce) m.cdir = dir;
            m.age++;
            if (m.age % SD == 0) begin
                tgt = m.idx + (m.cdir ? -1 : 1);
                if (tgt >= 0 && tgt <= MAXI) m.idx = tgt;
                else if (bounce) m.cdir = ~m.cdir;
                else m.halted = 1;
            end
        end
        m.step = (m.idx != old);
        return m;
    endfunction

    function automatic logic [TW-1:0] bar(int idx);
        logic [TW-1:0] b;
        b = '0;
        for (int i = 0; i < TW; i++)
            if (i <= TW - 1 - idx && i > TW - 1 - idx - CW) b[i] = 1'b1;
        return b;
    endfunction

    task automatic cmp8(string nm, logic [7:0] act, logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp1(string nm, logic act, logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(string nm, logic [7:0] pos, logic st, logic mv,
                             logic ar, logic al, logic arr, m_t m);
        cmp8({nm, ".POS"}, pos, bar(m.idx));
        cmp1({nm, ".STEP"}, st, m.step);
        cmp1({nm, ".MOVING"}, mv, m.auto_on && !m.halted);
        cmp1({nm, ".ARMED"}, ar, m.arm != 0);
        cmp1({nm, ".AT_LEFT"}, al, m.idx == 0);
        cmp1({nm, ".AT_RIGHT"}, arr, m.idx == MAXI);
    endtask

    always @(posedge CLK) begin
        m0 = mstep(m0, 1'b0, if0.RIGHT, if0.LEFT, if0.DIR, if0.AUTO, RESET);
        m1 = mstep(m1, 1'b1, if1.RIGHT, if1.LEFT, if1.DIR, if1.AUTO, RESET);
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk_model("u0", if0.POS, if0.STEP, if0.MOVING, if0.ARMED,
                      if0.AT_LEFT, if0.AT_RIGHT, m0);
            chk_model("u1", if1.POS, if1.STEP, if1.MOVING, if1.ARMED,
                      if1.AT_LEFT, if1.AT_RIGHT, m1);
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(int u, bit right);
        if (u == 0) begin
            if (right) if0.RIGHT = 1'b1;
            else       if0.LEFT  = 1'b1;
        end else begin
            if (right) if1.RIGHT = 1'b1;
            else       if1.LEFT  = 1'b1;
        end
        cyc(1);
        if0.RIGHT = 1'b0; if0.LEFT = 1'b0;
        if1.RIGHT = 1'b0; if1.LEFT = 1'b0;
    endtask

    task automatic rst_pulse();
        RESET = 1'b1;
        cyc(1);
        RESET = 1'b0;
    endtask

    logic [7:0] seq [5];

    initial begin
        seq = '{8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};
        if0.RIGHT = 0; if0.LEFT = 0; if0.DIR = 0; if0.AUTO = 0;
        if1.RIGHT = 0; if1.LEFT = 0; if1.DIR = 0; if1.AUTO = 0;
        m0 = mstep(m0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        m1 = mstep(m1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        cyc(2);
        chk_en = 1'b1;
        cmp8("reset POS", if0.POS, 8'hC0);
        cmp1("reset AT_LEFT", if0.AT_LEFT, 1'b1);
        cmp1("reset AT_RIGHT", if0.AT_RIGHT, 1'b0);
        cmp1("reset STEP", if0.STEP, 1'b0);
        cmp1("reset MOVING", if0.MOVING, 1'b0);
        cmp1("reset ARMED", if0.ARMED, 1'b0);
        RESET = 1'b0;

        press(0, 1'b1);
        cmp1("arm right ARMED", if0.ARMED, 1'b1);
        cyc(2);
        press(0, 1'b0);
        cmp8("confirm right POS", if0.POS, 8'h60);
        cmp1("confirm right STEP", if0.STEP, 1'b1);
        cmp1("confirm disarms", if0.ARMED, 1'b0);
        cyc(1);
        cmp1("STEP one cycle", if0.STEP, 1'b0);
        press(0, 1'b1);
        press(0, 1'b1);
        cmp8("cancel POS", if0.POS, 8'h60);
        cmp1("cancel ARMED", if0.ARMED, 1'b0);

        rst_pulse();
        cmp8("auto start POS", if0.POS, 8'hC0);
        if0.DIR = 1'b0;
        if0.AUTO = 1'b1;
        cyc(4);
        cmp8("auto no early step", if0.POS, 8'hC0);
        cyc(1);
        cmp8("auto first step", if0.POS, 8'h60);
        cmp1("auto MOVING", if0.MOVING, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(4);
            cmp8("auto step seq", if0.POS, seq[i]);
            cmp1("auto step pulse", if0.STEP, 1'b1);
        end
        cyc(4);
        cmp8("halt POS", if0.POS, 8'h03);
        cmp1("halt MOVING", if0.MOVING, 1'b0);
        cmp1("halt AT_RIGHT", if0.AT_RIGHT, 1'b1);
        if0.DIR = 1'b1;
        cyc(5);
        cmp8("resume left", if0.POS, 8'h06);
        if0.AUTO = 1'b0;
        cyc(1);

        for (int i = 0; i < 5; i++) begin
            press(1, 1'b1);
            press(1, 1'b0);
        end
        cmp8("bounce start POS", if1.POS, 8'h06);
        if1.DIR = 1'b0;
        if1.AUTO = 1'b1;
        cyc(1);
        for (int c = 1; c <= 12; c++) begin
            if1.DIR = ~if1.DIR;
            cyc(1);
            if (c == 4) cmp8("bounce to wall", if1.POS, 8'h03);
            if (c == 8) begin
                cmp8("dwell POS", if1.POS, 8'h03);
                cmp1("dwell STEP", if1.STEP, 1'b0);
            end
            if (c == 12) cmp8("bounce away", if1.POS, 8'h06);
        end
        if1.AUTO = 1'b0;
        cyc(1);

        rst_pulse();
        press(0, 1'b0);
        press(0, 1'b1);
        cmp8("left wall POS", if0.POS, 8'hC0);
        cmp1("left wall STEP", if0.STEP, 1'b0);
        if0.RIGHT = 1'b1;
        if0.LEFT = 1'b1;
        cyc(1);
        if0.RIGHT = 1'b0;
        if0.LEFT = 1'b0;
        cmp1("both pressed ARMED", if0.ARMED, 1'b0);
        if0.DIR = 1'b0;
        if0.AUTO = 1'b1;
        cyc(13);
        cmp8("mid run POS", if0.POS, 8'h18);
        if0.AUTO = 1'b0;
        cyc(1);
        cmp8("auto drop POS", if0.POS, 8'h18);
        cmp1("auto drop MOVING", if0.MOVING, 1'b0);
        cyc(4);
        cmp8("auto drop hold", if0.POS, 8'h18);

        rst_pulse();
        if0.AUTO = 1'b1;
        cyc(17);
        cmp8("pre reset POS", if0.POS, 8'h0C);
        rst_pulse();
        cmp8("reset mid run POS", if0.POS, 8'hC0);
        cmp1("reset mid run MOVING", if0.MOVING, 1'b0);
        cyc(4);
        cmp8("restart no early step", if0.POS, 8'hC0);
        cyc(1);
        cmp8("restart first step", if0.POS, 8'h60);
        if0.AUTO = 1'b0;
        cyc(1);

        for (int n = 0; n < 3000; n++) begin
            if0.RIGHT = ($urandom_range(0, 4) == 0);
            if0.LEFT  = ($urandom_range(0, 4) == 0);
            if1.RIGHT = ($urandom_range(0, 4) == 0);
            if1.LEFT  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 39) == 0) if0.AUTO = ~if0.AUTO;
            if ($urandom_range(0, 39) == 0) if1.AUTO = ~if1.AUTO;
            if ($urandom_range(0, 14) == 0) if0.DIR = ~if0.DIR;
            if ($urandom_range(0, 14) == 0) if1.DIR = ~if1.DIR;
            RESET = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        RESET = 1'b0;
        if0.RIGHT = 0; if0.LEFT = 0;
        if1.RIGHT = 0; if1.LEFT = 0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
